vga_pattern_sequencer: RTL

- Selects which test pattern the VGA output stage displays, and sequences pattern changes so they happen only at a frame boundary. No mid-frame tearing.
- Manual mode: the pattern index follows the board switches.
- Auto (slideshow) mode: the pattern index cycles through all patterns, dwelling a fixed number of frames on each. Pause and single-step are supported.
- Sits between the H/V timing generator (column/row counters), the switches/buttons, and the pattern-select mux.

---
 rtl/vga_pattern_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vga_pattern_sequencer.sv
// Picks the test pattern index for the VGA mux; every change is
// deferred to the frame boundary so a frame never shows two patterns.
module vga_pattern_sequencer #(
   parameter int TOTAL_COLS   = 800,
   parameter int TOTAL_ROWS   = 525,
   parameter int NUM_PATTERNS = 8,
   parameter int DWELL_FRAMES = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] col_count,
   input  logic [9:0] row_count,
   input  logic [2:0] sw_sel,
   input  logic       auto_en,
   input  logic       pause,
   input  logic       step,
   output logic [2:0] pat_sel,
   output logic       frame_tick,
   output logic       pat_changed,
   output logic       auto_active,
   output logic [7:0] dwell_count
);

   // Decode one pixel early so the registered tick lands on the last pixel.
   localparam logic [9:0] TICK_COL   = 10'(TOTAL_COLS - 2);
   localparam logic [9:0] TICK_ROW   = 10'(TOTAL_ROWS - 1);
   localparam logic [2:0] LAST_PAT   = 3'(NUM_PATTERNS - 1);
   localparam logic [7:0] LAST_DWELL = 8'(DWELL_FRAMES - 1);

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      AUTO   = 2'd1,
      HOLD   = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] pat_q, pat_d;
   logic [7:0] dwell_q, dwell_d;
   logic       pend_q, pend_d;
   logic       tick_q, tick_d;
   logic       chg_q, chg_d;
   logic       act_q, act_d;

   logic       step_hold;
   logic       step_eff;
   logic [2:0] pat_adv;

   assign tick_d = (col_count == TICK_COL) &&
                   (row_count == TICK_ROW);

   assign step_hold = step && (state_q == HOLD);
   assign step_eff  = pend_q || step_hold;

   // Wrapping here also pulls an out-of-range manual index back to 0.
   assign pat_adv = (pat_q >= LAST_PAT) ? 3'd0
                                        : pat_q + 3'd1;

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      dwell_d = dwell_q;
      pend_d  = pend_q || step_hold;
      if (tick_q) begin
         pend_d = 1'b0;
         unique case (state_q)
            MANUAL: begin
               if (auto_en) begin
                  state_d = AUTO;
                  dwell_d = 8'd0;
               end else begin
                  pat_d = sw_sel;
               end
            end
            AUTO: begin
               if (!auto_en) begin
                  state_d = MANUAL;
                  pat_d   = sw_sel;
                  dwell_d = 8'd0;
               end else if (pause) begin
                  state_d = HOLD;
               end else if (dwell_q == LAST_DWELL) begin
                  pat_d   = pat_adv;
                  dwell_d = 8'd0;
               end else begin
                  dwell_d = dwell_q + 8'd1;
               end
            end
            HOLD: begin
               if (!auto_en) begin
                  state_d = MANUAL;
                  pat_d   = sw_sel;
                  dwell_d = 8'd0;
               end else if (!pause) begin
                  state_d = AUTO;
               end else if (step_eff) begin
                  pat_d   = pat_adv;
                  dwell_d = 8'd0;
               end
            end
            default: begin
               state_d = MANUAL;
               pat_d   = sw_sel;
               dwell_d = 8'd0;
            end
         endcase
      end
      chg_d = (pat_d != pat_q);
      act_d = (state_d != MANUAL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MANUAL;
         pat_q   <= 3'd0;
         dwell_q <= 8'd0;
         pend_q  <= 1'b0;
         tick_q  <= 1'b0;
         chg_q   <= 1'b0;
         act_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         dwell_q <= dwell_d;
         pend_q  <= pend_d;
         tick_q  <= tick_d;
         chg_q   <= chg_d;
         act_q   <= act_d;
      end
   end

   assign pat_sel     = pat_q;
   assign frame_tick  = tick_q;
   assign pat_changed = chg_q;
   assign auto_active = act_q;
   assign dwell_count = dwell_q;

endmodule
